// File: rtl/uart_core_if.sv
// Host-side and pin-side signals of uart_core, bundled as one port.
// slave: the UART itself; master: whatever drives it (host logic plus the rx pin).
`timescale 1ns/1ps
interface uart_core_if;
    logic [7:0] din;
    logic       wr_en;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic       rdy;
    logic       rdy_clr;
    logic [7:0] dout;

    modport slave (
        input  din, wr_en, rx, rdy_clr,
        output tx, tx_busy, rdy, dout
    );

    modport master (
        output din, wr_en, rx, rdy_clr,
        input  tx, tx_busy, rdy, dout
    );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8-bit UART, 8N1 by default; defining UART_PARITY_EN switches the frame to 8E1.
// TX holds each bit TX_DIV clocks; RX oversamples 16x on a free-running tick every RX_DIV clocks.
`timescale 1ns/1ps
module uart_core #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clock,
    input  logic       reset_n,
    uart_core_if.slave bus
);
    localparam int TX_DIV = CLK_HZ / BAUD;
    localparam int RX_DIV = CLK_HZ / (16 * BAUD);
`ifdef UART_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int TXW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam int RXW = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam logic [TXW-1:0] TX_LAST  = TXW'(TX_DIV - 1);
    localparam logic [RXW-1:0] RX_LAST  = RXW'(RX_DIV - 1);
    localparam logic [3:0]     BIT_LAST = 4'(NB - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- transmitter ----------------
    state_t          tx_state_q, tx_state_d;
    logic [TXW-1:0]  tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [NB-1:0]   tx_shr_q, tx_shr_d;
    logic            tx_q, tx_d;
    logic            tx_busy_q, tx_busy_d;
    logic            tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == TX_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shr_q   <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shr_q   <= tx_shr_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shr_d   = tx_shr_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        if (tx_state_q != IDLE)
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + TXW'(1);
        case (tx_state_q)
            IDLE: begin
                // wr_en is only honoured here, so writes during a frame are dropped
                if (bus.wr_en) begin
                    tx_state_d = START;
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
`ifdef UART_PARITY_EN
                    tx_shr_d   = {^bus.din, bus.din};
`else
                    tx_shr_d   = bus.din;
`endif
                end
            end
            START: begin
                if (tx_bit_end) begin
                    tx_state_d = DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shr_q[0];
                end
            end
            DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_shr_d = tx_shr_q >> 1;
                        tx_d     = tx_shr_q[1];
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tx_bit_end) begin
                    tx_state_d = IDLE;
                    tx_busy_d  = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = tx_busy_q;

    // ---------------- receiver ----------------
    logic            rx_s1_q, rx_s2_q;
    logic [RXW-1:0]  div_q, div_d;
    logic            tick;
    state_t          rx_state_q, rx_state_d;
    logic [3:0]      rx_tcnt_q, rx_tcnt_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [NB-1:0]   rx_shr_q, rx_shr_d;
    logic [7:0]      dout_q, dout_d;
    logic            rdy_q, rdy_d;
    logic            rx_done;
    logic            rx_par_ok;

    assign tick  = (div_q == RX_LAST);
    assign div_d = tick ? '0 : div_q + RXW'(1);

`ifdef UART_PARITY_EN
    assign rx_par_ok = ~^rx_shr_q;
`else
    assign rx_par_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            div_q      <= '0;
            rx_state_q <= IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_shr_q   <= '0;
            dout_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            rx_s1_q    <= bus.rx;
            rx_s2_q    <= rx_s1_q;
            div_q      <= div_d;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shr_q   <= rx_shr_d;
            dout_q     <= dout_d;
            rdy_q      <= rdy_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shr_d   = rx_shr_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = START;
                    rx_tcnt_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_tcnt_q == 4'd7) begin
                        rx_tcnt_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_s2_q ? IDLE : DATA;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                // 4-bit tick counter wraps 15->0, giving one sample per 16 ticks
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_shr_d = {rx_s2_q, rx_shr_q[NB-1:1]};
                        if (rx_bit_q == BIT_LAST) rx_state_d = STOP;
                        else                      rx_bit_d   = rx_bit_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_state_d = IDLE;
                        rx_done    = rx_s2_q & rx_par_ok;
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // a completing byte beats a simultaneous clear
    assign rdy_d  = (rdy_q & ~bus.rdy_clr) | rx_done;
    assign dout_d = rx_done ? rx_shr_q[7:0] : dout_q;

    assign bus.rdy  = rdy_q;
    assign bus.dout = dout_q;
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core at 16 clocks per bit (RX_DIV=1): loopback and directly driven rx.
`timescale 1ns/1ps
module tb_uart_core;
    localparam int CLK_HZ   = 1600000;
    localparam int BAUD     = 100000;
    localparam int BIT_CLKS = CLK_HZ / BAUD;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CLKS = FB * BIT_CLKS;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic loop_en = 1'b1;
    logic rx_drv  = 1'b1;
    int   total   = 0;
    int   bad     = 0;
    logic [7:0] dout_m;
    logic       rdy_m;

    uart_core_if bus();
    assign bus.rx = loop_en ? bus.tx : rx_drv;

    uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame as seen on the wire, index 0 = start bit; indices past the stop bit are idle-high.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        logic [10:0] f;
`ifdef UART_PARITY_EN
        f = {1'b1, ^b, b, 1'b0};
`else
        f = {2'b11, b, 1'b0};
`endif
        return f[idx];
    endfunction

    task automatic send_byte(input logic [7:0] b, input int inject_at, input logic hold_clr);
        int busy_n = 0;
        int line_err = 0;
        logic got = 1'b0;
        logic tx0 = 1'b1;
        logic [7:0] dout_at = 8'h00;
        @(posedge clock); #1;
        bus.din = b; bus.wr_en = 1'b1; bus.rdy_clr = hold_clr;
        @(posedge clock); #1;
        bus.wr_en = 1'b0;
        for (int k = 0; k < FRAME_CLKS + 24; k++) begin
            @(negedge clock);
            if (k == 0) tx0 = bus.tx;
            if (bus.tx_busy === 1'b1) busy_n++;
            if (k >= FRAME_CLKS) begin
                if (bus.tx !== 1'b1) line_err++;
            end else if (k % BIT_CLKS == BIT_CLKS / 2) begin
                if (bus.tx !== frame_bit(b, k / BIT_CLKS)) line_err++;
            end
            if (!got && bus.rdy === 1'b1) begin
                got = 1'b1;
                dout_at = bus.dout;
            end
            if (k == inject_at) begin bus.din = 8'hFF; bus.wr_en = 1'b1; end
            if (k == inject_at + 1) bus.wr_en = 1'b0;
        end
        bus.rdy_clr = 1'b0;
        check("tx_start_low", tx0, 1'b0);
        check("busy_len", busy_n, FRAME_CLKS);
        check("line_bits", line_err, 0);
        check("rdy_rise", got, 1'b1);
        check("dout_loop", dout_at, b);
        dout_m = b;
        if (!hold_clr) begin
            check("rdy_sticky", bus.rdy, 1'b1);
            @(posedge clock); #1 bus.rdy_clr = 1'b1;
            @(posedge clock); #1 bus.rdy_clr = 1'b0;
            @(negedge clock);
            check("rdy_cleared", bus.rdy, 1'b0);
        end
        rdy_m = 1'b0;
        $display("tx byte=0x%02h busy=%0d line_err=%0d rdy=%0d dout=0x%02h", b, busy_n, line_err, got, dout_at);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        logic [10:0] f;
        logic ok;
`ifdef UART_PARITY_EN
        f  = {stop_bit, (^b) ^ par_flip, b, 1'b0};
        ok = stop_bit && !par_flip;
`else
        f  = {1'b1, stop_bit, b, 1'b0};
        ok = stop_bit;
`endif
        for (int i = 0; i < FB; i++) begin
            @(posedge clock); #1 rx_drv = f[i];
            repeat (BIT_CLKS - 1) @(posedge clock);
        end
        @(posedge clock); #1 rx_drv = 1'b1;
        repeat (24) @(posedge clock);
        if (ok) begin dout_m = b; rdy_m = 1'b1; end
        @(negedge clock);
        check("rx_rdy", bus.rdy, rdy_m);
        check("rx_dout", bus.dout, dout_m);
        $display("rx byte=0x%02h stop=%0d pflip=%0d -> rdy=%0d dout=0x%02h", b, stop_bit, par_flip, bus.rdy, bus.dout);
    endtask

    task automatic clear_rdy();
        @(posedge clock); #1 bus.rdy_clr = 1'b1;
        @(posedge clock); #1 bus.rdy_clr = 1'b0;
        rdy_m = 1'b0;
        @(negedge clock);
        check("rdy_clr_rx", bus.rdy, 1'b0);
    endtask

    initial begin
        int idle_err;
        bus.din = 8'h00; bus.wr_en = 1'b0; bus.rdy_clr = 1'b0;
        dout_m = 8'h00; rdy_m = 1'b0;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_tx", bus.tx, 1'b1);
        check("rst_busy", bus.tx_busy, 1'b0);
        check("rst_rdy", bus.rdy, 1'b0);
        check("rst_dout", bus.dout, 8'h00);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // single byte in loopback, then full sweep
        send_byte(8'hA5, -10, 1'b0);
        for (int b = 0; b < 256; b++) send_byte(8'(b), -10, 1'b0);
        check("sweep_last", bus.dout, 8'hFF);

        // write during busy is ignored
        send_byte(8'h3C, 50, 1'b0);
        idle_err = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) idle_err++;
        end
        check("no_second_frame", idle_err, 0);

        // rdy_clr held across completion: set must win
        send_byte(8'h96, -10, 1'b1);

        // random loopback bytes
        repeat (8) send_byte(8'($urandom_range(0, 255)), -10, 1'b0);

        // receiver error cases with rx driven directly
        loop_en = 1'b0;
        @(posedge clock); #1 rx_drv = 1'b0;
        repeat (4) @(posedge clock);
        #1 rx_drv = 1'b1;
        repeat (40) @(negedge clock);
        check("glitch_rdy", bus.rdy, rdy_m);
        check("glitch_dout", bus.dout, dout_m);
        $display("rx glitch 4 clocks -> rdy=%0d dout=0x%02h", bus.rdy, bus.dout);
        rx_frame(8'h55, 1'b0, 1'b0);
        rx_frame(8'h81, 1'b1, 1'b0);
        check("valid_81", bus.dout, 8'h81);

        // random frames with occasional framing/parity errors
        for (int i = 0; i < 12; i++) begin
            rx_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) clear_rdy();
        end

        // reset in the middle of a transmission
        rx_frame(8'hC3, 1'b1, 1'b0);
        loop_en = 1'b1;
        @(posedge clock); #1 bus.din = 8'h5A; bus.wr_en = 1'b1;
        @(posedge clock); #1 bus.wr_en = 1'b0;
        repeat (40) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_tx", bus.tx, 1'b1);
        check("midrst_busy", bus.tx_busy, 1'b0);
        check("midrst_rdy", bus.rdy, 1'b0);
        check("midrst_dout", bus.dout, 8'h00);
        $display("reset mid-frame -> tx=%0d busy=%0d rdy=%0d dout=0x%02h", bus.tx, bus.tx_busy, bus.rdy, bus.dout);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (300) @(negedge clock);
        check("post_rst_rdy", bus.rdy, 1'b0);
        check("post_rst_dout", bus.dout, 8'h00);
        check("post_rst_tx", bus.tx, 1'b1);
        check("post_rst_busy", bus.tx_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
